// File: rtl/ysyx_ifu.sv
// rtl/ysyx_ifu.sv - instruction fetch unit: PC, AR/R read bus master, inst valid/ready to execute
// One fetch in flight at a time; every output is decoded from registered state.
module ysyx_ifu #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] araddr,
  output logic            arvalid,
  input  logic            arready,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_addr,
  output logic            fetch_err,
  output logic [XLEN-1:0] err_pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [XLEN-1:0] err_pc_q, err_pc_d;
  logic            fetch_err_q, fetch_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      err_pc_q    <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      err_pc_q    <= err_pc_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    err_pc_d    = err_pc_q;
    fetch_err_d = fetch_err_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (arready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rvalid) begin
          if (rresp == 2'b00) begin
            inst_d    = rdata;
            inst_pc_d = pc_q;
            state_d   = S_HOLD;
          end else begin
            err_pc_d    = pc_q;
            fetch_err_d = 1'b1;
            state_d     = S_ERR;
          end
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          // A misaligned redirect target is fatal; pc keeps the last good value.
          if (jump_en && (jump_addr[1:0] != 2'b00)) begin
            err_pc_d    = jump_addr;
            fetch_err_d = 1'b1;
            state_d     = S_ERR;
          end else begin
            pc_d    = jump_en ? jump_addr : pc_q + XLEN'(4);
            state_d = S_REQ;
          end
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  assign arvalid    = (state_q == S_REQ);
  assign rready     = (state_q == S_WAIT);
  assign inst_valid = (state_q == S_HOLD);
  assign araddr     = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign err_pc     = err_pc_q;
  assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_ysyx_ifu.sv
// tb/tb_ysyx_ifu.sv - self-checking bench for ysyx_ifu
// Directed vector table, hand-written corner sequences, then random traffic against a fetch-stream model.
module tb_ysyx_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        fetch_err;
  logic [31:0] err_pc;

  int checks   = 0;
  int failures = 0;

  ysyx_ifu #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .jump_en(jump_en), .jump_addr(jump_addr),
    .fetch_err(fetch_err), .err_pc(err_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ar;
    logic        rv;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        ir;
    logic        je;
    logic [31:0] ja;
    logic [2:0]  e_hs;
    logic [31:0] e_araddr;
    logic [31:0] e_inst;
    logic [31:0] e_inst_pc;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_hs(input string name, input logic [2:0] exp);
    chk(name, {29'b0, arvalid, rready, inst_valid}, {29'b0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ar, input logic rv, input logic [31:0] rd, input logic [1:0] rr,
                        input logic ir, input logic je, input logic [31:0] ja);
    arready    = ar;
    rvalid     = rv;
    rdata      = rd;
    rresp      = rr;
    inst_ready = ir;
    jump_en    = je;
    jump_addr  = ja;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk_hs("rst_hs", 3'b000);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_araddr", araddr, 32'h8000_0000);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_err_pc", err_pc, 32'd0);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic ar, input logic rv, input logic [31:0] rd, input logic ir,
                              input logic je, input logic [31:0] ja, input logic [2:0] hs,
                              input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.ar = ar; v.rv = rv; v.rd = rd; v.rr = 2'b00; v.ir = ir; v.je = je; v.ja = ja;
    v.e_hs = hs; v.e_araddr = ea; v.e_inst = ei; v.e_inst_pc = ep;
    return v;
  endfunction

  initial begin
    logic [31:0] model_pc;
    logic        pending;
    int          retired;
    int          since_retire;

    // Row order: the state the row lives in is visible in e_hs (100=REQ, 010=WAIT, 001=HOLD).
    vecs[0]  = mk(0, 1, 32'hDEAD_BEEF, 0, 0, 0,            3'b000, 32'h8000_0000, 32'h0,         32'h0);
    vecs[1]  = mk(1, 0, 0,             0, 0, 0,            3'b100, 32'h8000_0000, 32'h0,         32'h0);
    vecs[2]  = mk(0, 1, 32'h13,        0, 0, 0,            3'b010, 32'h8000_0000, 32'h0,         32'h0);
    vecs[3]  = mk(0, 0, 0,             1, 0, 0,            3'b001, 32'h8000_0000, 32'h13,        32'h8000_0000);
    vecs[4]  = mk(1, 0, 0,             0, 0, 0,            3'b100, 32'h8000_0004, 32'h13,        32'h8000_0000);
    vecs[5]  = mk(0, 1, 32'h13,        0, 0, 0,            3'b010, 32'h8000_0004, 32'h13,        32'h8000_0000);
    vecs[6]  = mk(0, 0, 0,             1, 0, 0,            3'b001, 32'h8000_0004, 32'h13,        32'h8000_0004);
    vecs[7]  = mk(1, 0, 0,             0, 0, 0,            3'b100, 32'h8000_0008, 32'h13,        32'h8000_0004);
    vecs[8]  = mk(0, 1, 32'h13,        0, 0, 0,            3'b010, 32'h8000_0008, 32'h13,        32'h8000_0004);
    vecs[9]  = mk(0, 0, 0,             1, 0, 0,            3'b001, 32'h8000_0008, 32'h13,        32'h8000_0008);
    vecs[10] = mk(1, 0, 0,             0, 0, 0,            3'b100, 32'h8000_000C, 32'h13,        32'h8000_0008);
    vecs[11] = mk(0, 1, 32'h0010_0093, 0, 0, 0,            3'b010, 32'h8000_000C, 32'h13,        32'h8000_0008);
    vecs[12] = mk(0, 0, 0,             0, 1, 32'h8000_0200, 3'b001, 32'h8000_000C, 32'h0010_0093, 32'h8000_000C);
    vecs[13] = mk(0, 0, 0,             1, 1, 32'h8000_0100, 3'b001, 32'h8000_000C, 32'h0010_0093, 32'h8000_000C);
    vecs[14] = mk(1, 0, 0,             0, 0, 0,            3'b100, 32'h8000_0100, 32'h0010_0093, 32'h8000_000C);
    vecs[15] = mk(0, 1, 32'h13,        0, 0, 0,            3'b010, 32'h8000_0100, 32'h0010_0093, 32'h8000_000C);
    vecs[16] = mk(0, 0, 0,             1, 0, 0,            3'b001, 32'h8000_0100, 32'h13,        32'h8000_0100);
    vecs[17] = mk(0, 0, 0,             0, 0, 0,            3'b100, 32'h8000_0104, 32'h13,        32'h8000_0100);

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      set_in(vecs[i].ar, vecs[i].rv, vecs[i].rd, vecs[i].rr, vecs[i].ir, vecs[i].je, vecs[i].ja);
      chk_hs($sformatf("vec%0d_hs", i), vecs[i].e_hs);
      chk($sformatf("vec%0d_araddr", i), araddr, vecs[i].e_araddr);
      chk($sformatf("vec%0d_inst", i), inst, vecs[i].e_inst);
      chk($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].e_inst_pc);
      step();
    end

    // Memory stalls, downstream stall, then an error response at 80000008.
    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0);
      chk_hs("ar_stall_hs", 3'b100);
      chk("ar_stall_araddr", araddr, 32'h8000_0000);
      step();
    end
    set_in(1, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 32'hBAD0_0000 + i, 0, 0, 0, 0);
      chk_hs("r_stall_hs", 3'b010);
      chk("r_stall_inst", inst, 32'd0);
      step();
    end
    set_in(0, 1, 32'hCAFE_0013, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 32'h8000_0040);
      chk_hs("ds_stall_hs", 3'b001);
      chk("ds_stall_inst", inst, 32'hCAFE_0013);
      chk("ds_stall_inst_pc", inst_pc, 32'h8000_0000);
      step();
    end
    set_in(0, 0, 0, 0, 1, 0, 0);
    step();
    chk_hs("after_ds_hs", 3'b100);
    chk("after_ds_araddr", araddr, 32'h8000_0004);
    set_in(1, 0, 0, 0, 0, 0, 0);
    step();
    set_in(0, 1, 32'h13, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 1, 0, 0);
    step();
    chk("rresp_araddr", araddr, 32'h8000_0008);
    set_in(1, 0, 0, 0, 0, 0, 0);
    step();
    set_in(0, 1, 32'h13, 2'b10, 0, 0, 0);
    step();
    for (int i = 0; i < 12; i++) begin
      chk_hs("rresp_err_hs", 3'b000);
      chk("rresp_fetch_err", {31'b0, fetch_err}, 32'd1);
      chk("rresp_err_pc", err_pc, 32'h8000_0008);
      set_in(1, 1, $urandom(), 0, 1, 1, 32'h8000_0000);
      step();
    end

    // Misaligned redirect target.
    do_reset();
    step();
    set_in(1, 0, 0, 0, 0, 0, 0);
    step();
    set_in(0, 1, 32'h13, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 1, 1, 32'h8000_0102);
    step();
    for (int i = 0; i < 4; i++) begin
      chk_hs("jerr_hs", 3'b000);
      chk("jerr_fetch_err", {31'b0, fetch_err}, 32'd1);
      chk("jerr_err_pc", err_pc, 32'h8000_0102);
      chk("jerr_pc_kept", araddr, 32'h8000_0000);
      set_in(1, 1, 0, 0, 1, 0, 0);
      step();
    end

    // Asynchronous reset in the middle of a WAIT cycle, then a stale rvalid during IDLE.
    do_reset();
    step();
    set_in(1, 0, 0, 0, 0, 0, 0);
    step();
    set_in(0, 1, 32'h13, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 1, 0, 0);
    step();
    set_in(1, 0, 0, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk_hs("pre_arst_hs", 3'b010);
    chk("pre_arst_inst", inst, 32'h13);
    #3;
    rst = 1'b1;
    #1;
    chk_hs("arst_hs", 3'b000);
    chk("arst_araddr", araddr, 32'h8000_0000);
    chk("arst_inst", inst, 32'd0);
    chk("arst_inst_pc", inst_pc, 32'd0);
    step();
    rst = 1'b0;
    set_in(0, 1, 32'hBAD0_BAD0, 0, 0, 0, 0);
    chk_hs("stale_idle_hs", 3'b000);
    step();
    chk_hs("stale_req_hs", 3'b100);
    chk("stale_req_araddr", araddr, 32'h8000_0000);
    chk("stale_inst", inst, 32'd0);
    set_in(1, 0, 0, 0, 0, 0, 0);
    step();
    set_in(0, 1, 32'h13, 0, 0, 0, 0);
    step();
    chk_hs("post_arst_hs", 3'b001);
    chk("post_arst_inst", inst, 32'h13);
    chk("post_arst_inst_pc", inst_pc, 32'h8000_0000);

    // Random traffic: the model is the expected PC stream plus one outstanding read.
    do_reset();
    model_pc     = 32'h8000_0000;
    pending      = 1'b0;
    retired      = 0;
    since_retire = 0;
    for (int c = 0; c < 4000; c++) begin
      logic [31:0] ja;
      logic        je;
      ja = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) ja = 32'hFFFF_FFFC;
      je = ($urandom_range(0, 3) == 0);
      set_in($urandom_range(0, 1), pending && ($urandom_range(0, 1) == 1), memf(araddr),
             2'b00, $urandom_range(0, 1), je, ja);
      if (pending) rdata = memf(model_pc);
      chk("rnd_fetch_err", {31'b0, fetch_err}, 32'd0);
      if ((32'(arvalid) + 32'(rready) + 32'(inst_valid)) > 1) chk_hs("rnd_onehot", 3'b000);
      if (arvalid) begin
        chk("rnd_araddr", araddr, model_pc);
        chk("rnd_ar_while_pending", {31'b0, pending}, 32'd0);
        if (arready) pending = 1'b1;
      end
      if (rready && rvalid) pending = 1'b0;
      if (inst_valid) begin
        chk("rnd_inst", inst, memf(model_pc));
        chk("rnd_inst_pc", inst_pc, model_pc);
        if (inst_ready) begin
          model_pc     = je ? ja : model_pc + 32'd4;
          retired++;
          since_retire = 0;
        end
      end
      since_retire++;
      if (since_retire > 300) begin
        chk("rnd_watchdog", 32'(since_retire), 32'd0);
        break;
      end
      step();
    end
    chk("rnd_retired_enough", 32'(retired > 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
